// File: rtl/uart_pkg.sv
// uart_pkg: shared UART state encoding, data width, parity and frame-length helpers
package uart_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} uart_state_e;
  localparam int DATA_BITS = 8;
  function automatic logic parity_bit(input logic [DATA_BITS-1:0] b, input logic odd);
    return (^b) ^ odd;
  endfunction
  function automatic int frame_bits(input int parity_en, input int stop_bits);
    return 1 + DATA_BITS + parity_en + stop_bits;
  endfunction
endpackage

// File: rtl/uart_bit_timer.sv
// uart_bit_timer: bit-period counter (clk, reset_n, clear, en in; bit_tick out at count CLKS_PER_BIT-1)
module uart_bit_timer #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  input  logic en,
  output logic bit_tick
);
  localparam int W = CLKS_PER_BIT > 1 ? $clog2(CLKS_PER_BIT) : 1;
  logic [W-1:0] count_q, count_d;
  assign bit_tick = en && count_q == W'(CLKS_PER_BIT - 1);
  always_comb count_d = (clear || bit_tick) ? '0 : en ? count_q + 1'b1 : count_q;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) count_q <= '0;
    else count_q <= count_d;
endmodule

// File: rtl/uart_tx_controller.sv
// uart_tx_controller: UART transmitter (valid/ready byte in; registered serial, ready, active, done-pulse out)
module uart_tx_controller
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 i_Tx_Valid,
  input  logic [DATA_BITS-1:0] i_Tx_Byte,
  output logic                 o_Tx_Ready,
  output logic                 o_Tx_Serial,
  output logic                 o_Tx_Active,
  output logic                 o_Tx_Done
);
  if (CLKS_PER_BIT < 2 || !(STOP_BITS == 1 || STOP_BITS == 2)) begin : g_bad_params
    $error("uart_tx_controller: CLKS_PER_BIT must be >= 2 and STOP_BITS 1 or 2");
  end
  uart_state_e          state_q, state_d;
  logic [DATA_BITS-1:0] byte_q, byte_d;
  logic [2:0]           bit_idx_q, bit_idx_d;
  logic                 stop_q, stop_d;
  logic                 serial_q, serial_d;
  logic                 active_q, active_d;
  logic                 ready_q, ready_d;
  logic                 done_q, done_d;
  logic                 bit_tick, last_data, last_stop;
  uart_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_timer (
    .clk      (clk),
    .reset_n  (reset_n),
    .clear    (state_q == IDLE),
    .en       (state_q != IDLE),
    .bit_tick (bit_tick)
  );
  assign last_data = bit_idx_q == 3'd7;
  assign last_stop = stop_q == 1'(STOP_BITS - 1);
  always_comb begin
    state_d   = state_q;
    byte_d    = byte_q;
    bit_idx_d = bit_idx_q;
    stop_d    = stop_q;
    serial_d  = serial_q;
    active_d  = active_q;
    ready_d   = ready_q;
    done_d    = 1'b0;
    case (state_q)
      IDLE: if (i_Tx_Valid) begin
        state_d  = START;
        byte_d   = i_Tx_Byte;
        serial_d = 1'b0;
        active_d = 1'b1;
        ready_d  = 1'b0;
      end
      START: if (bit_tick) begin
        state_d  = DATA;
        serial_d = byte_q[0];
      end
      DATA: if (bit_tick) begin
        bit_idx_d = bit_idx_q + 3'd1;
        state_d   = !last_data ? DATA : (PARITY_EN != 0) ? PARITY : STOP;
        serial_d  = !last_data ? byte_q[bit_idx_q + 3'd1]
                  : (PARITY_EN != 0) ? parity_bit(byte_q, PARITY_ODD != 0) : 1'b1;
      end
      PARITY: if (bit_tick) begin
        state_d  = STOP;
        serial_d = 1'b1;
      end
      STOP: if (bit_tick) begin
        stop_d   = !last_stop;
        state_d  = last_stop ? IDLE : STOP;
        done_d   = last_stop;
        active_d = !last_stop;
        ready_d  = last_stop;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state_q   <= IDLE;
      byte_q    <= '0;
      bit_idx_q <= '0;
      stop_q    <= 1'b0;
      serial_q  <= 1'b1;
      active_q  <= 1'b0;
      ready_q   <= 1'b1;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      byte_q    <= byte_d;
      bit_idx_q <= bit_idx_d;
      stop_q    <= stop_d;
      serial_q  <= serial_d;
      active_q  <= active_d;
      ready_q   <= ready_d;
      done_q    <= done_d;
    end
  assign o_Tx_Ready  = ready_q;
  assign o_Tx_Serial = serial_q;
  assign o_Tx_Active = active_q;
  assign o_Tx_Done   = done_q;
endmodule
